// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU arbiter slice.
//   state_t      - arbiter FSM state encoding (IDLE, EXEC, RESP)
//   CTRL_*       - 3-bit ALU operation codes; 110/111 are illegal
//   FLAG_*       - bit positions inside the 4-bit {N,Z,C,V} flag vector
//   ctrl_valid() - returns 1 for a legal operation code
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_XOR = 3'b010;
  localparam logic [2:0] CTRL_BIC = 3'b011;
  localparam logic [2:0] CTRL_ADD = 3'b100;
  localparam logic [2:0] CTRL_SUB = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic ctrl_valid(input logic [2:0] ctrl);
    return (ctrl <= CTRL_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational 32-bit ALU.
//   a, b    in  32  operands
//   ctrl    in  3   operation code (alu_pkg::CTRL_*)
//   result  out 32  operation result (0 for an illegal code)
//   flags   out 4   {N,Z,C,V} of this operation (0000 for an illegal code)
//   err     out 1   illegal operation code
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  output logic              err
);

  logic [DATA_W:0] sum;
  logic            carry;
  logic            ovf;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = !ctrl_valid(ctrl);
    case (ctrl)
      CTRL_AND: result = a & b;
      CTRL_OR:  result = a | b;
      CTRL_XOR: result = a ^ b;
      CTRL_BIC: result = a & ~b;
      CTRL_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      CTRL_SUB: begin
        // a + ~b + 1: carry out means "no borrow"
        sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      default: result = '0;
    endcase

    flags = '0;
    if (!err) begin
      flags[FLAG_N] = result[DATA_W-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end to a single shared ALU.
//   clk, reset_n                 clock, async active-low reset
//   reqN_valid/ready             request handshake (N = 0,1)
//   reqN_a/b/ctrl/setflags       operation, sampled on accept only
//   rspN_valid/ready             response handshake
//   rspN_result/flags/err        response payload, held until consumed
//   flags                        architectural NZCV register
//   busy                         high whenever not IDLE
//
// state | meaning
// IDLE  | ready to grant one of the requesters
// EXEC  | ALU evaluates latched operands; result captured on exit
// RESP  | result presented to the latched requester until consumed
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_ctrl,
  input  logic              req0_setflags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_ctrl,
  input  logic              req1_setflags,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [FLAG_W-1:0] rsp0_flags,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic              rsp1_err,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              last_q, last_d;     // requester granted most recently
  logic              id_q, id_d;         // requester owning the transaction
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              setf_q, setf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0] rflags_q, rflags_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic              grant0, grant1;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic              alu_err;
  logic              rsp_done;

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .ctrl   (ctrl_q),
    .result (alu_result),
    .flags  (alu_flags),
    .err    (alu_err)
  );

  // On contention the requester not granted last wins.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign rsp_done = id_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    setf_d   = setf_q;
    result_d = result_q;
    rflags_d = rflags_q;
    err_d    = err_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d    = grant1;
          last_d  = grant1;
          a_d     = grant1 ? req1_a        : req0_a;
          b_d     = grant1 ? req1_b        : req0_b;
          ctrl_d  = grant1 ? req1_ctrl     : req0_ctrl;
          setf_d  = grant1 ? req1_setflags : req0_setflags;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        rflags_d = alu_flags;
        err_d    = alu_err;
        if (setf_q && !alu_err) flags_d = alu_flags;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      setf_q   <= 1'b0;
      result_q <= '0;
      rflags_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      setf_q   <= setf_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
    end
  end

  assign req0_ready  = (state_q == IDLE) && grant0;
  assign req1_ready  = (state_q == IDLE) && grant1;
  assign rsp0_valid  = (state_q == RESP) && !id_q;
  assign rsp1_valid  = (state_q == RESP) && id_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_flags  = rflags_q;
  assign rsp1_flags  = rflags_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;
  assign flags       = flags_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_setflags;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_ctrl;
  logic        req1_valid, req1_ready, req1_setflags;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] rsp0_result;
  logic [3:0]  rsp0_flags;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp1_result;
  logic [3:0]  rsp1_flags;
  logic [3:0]  flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_setflags(req0_setflags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_setflags(req1_setflags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the arbiter IDLE and the other requester idle.
  // Accept edge counts as edge 1; response is visible after edge 2.
  task automatic run_op(input string tag, input bit who, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic setf,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl,
                        input logic exp_err, input logic [3:0] exp_arch);
    if (!who) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_setflags = setf;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_setflags = setf;
    end
    #1;
    chk({tag, "_ready"}, {31'd0, who ? req1_ready : req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;   // post-accept changes must not matter
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_early_valid"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, who ? 32'd2 : 32'd1);
    chk({tag, "_result"}, who ? rsp1_result : rsp0_result, exp_res);
    chk({tag, "_rsp_flags"}, {28'd0, who ? rsp1_flags : rsp0_flags}, {28'd0, exp_fl});
    chk({tag, "_err"}, {31'd0, who ? rsp1_err : rsp0_err}, {31'd0, exp_err});
    chk({tag, "_arch_flags"}, {28'd0, flags}, {28'd0, exp_arch});
    if (!who) rsp0_ready = 1; else rsp1_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    chk({tag, "_done"}, {30'd0, rsp1_valid, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; req0_setflags = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; req1_setflags = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_result", rsp0_result, 32'd0);
    chk("rst_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
    @(negedge clk);
    reset_n = 1;

    // Single ops, including the flag-gating and illegal-code cases.
    run_op("sub_5_3",  0, 3'b101, 32'd5,          32'd3,          1, 32'd2,          4'b0010, 0, 4'b0010);
    run_op("add_wrap", 1, 3'b100, 32'hFFFF_FFFF,  32'd1,          0, 32'd0,          4'b0110, 0, 4'b0010);
    run_op("illegal",  0, 3'b111, 32'd7,          32'd9,          1, 32'd0,          4'b0000, 1, 4'b0010);
    run_op("illeg110", 1, 3'b110, 32'd7,          32'd9,          1, 32'd0,          4'b0000, 1, 4'b0010);
    run_op("add_ovf",  1, 3'b100, 32'h7FFF_FFFF,  32'd1,          1, 32'h8000_0000,  4'b1001, 0, 4'b1001);
    run_op("sub_neg",  0, 3'b101, 32'd3,          32'd5,          0, 32'hFFFF_FFFE,  4'b1000, 0, 4'b1001);
    run_op("xor_zero", 1, 3'b010, 32'hA5A5_A5A5,  32'hA5A5_A5A5,  1, 32'd0,          4'b0100, 0, 4'b0100);
    run_op("bic",      0, 3'b011, 32'hFFFF_0000,  32'h00FF_0000,  0, 32'hFF00_0000,  4'b1000, 0, 4'b0100);

    // Contention from reset with backpressure on requester 0.
    reset_n = 0;
    req0_valid = 1; req0_a = 32'hFF00_FF00; req0_b = 32'h0F0F_0F0F; req0_ctrl = 3'b000; req0_setflags = 0;
    req1_valid = 1; req1_a = 32'hF000_0000; req1_b = 32'h0000_0001; req1_ctrl = 3'b001; req1_setflags = 0;
    #1;
    chk("rst_flags_cleared", {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("cont_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("cont_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("cont_rsp_route0", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    chk("cont_result0", rsp0_result, 32'h0F00_0F00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_result_stable", rsp0_result, 32'h0F00_0F00);
      chk("bp_hold", {29'd0, req1_ready, rsp1_valid, rsp0_valid}, 32'd1);
    end
    rsp0_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp0_ready = 0;
    chk("cont_grant1", {29'd0, rsp0_valid, req1_ready, req0_ready}, 32'd2);
    @(posedge clk); @(negedge clk);
    rsp0_ready = 1;   // stray ready for the wrong requester
    chk("cont_exec1", {31'd0, busy}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("cont_rsp_route1", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    chk("cont_result1", rsp1_result, 32'hF000_0001);
    chk("cont_flags1", {28'd0, rsp1_flags}, 32'h8);
    @(posedge clk); @(negedge clk);
    chk("stray_ready_ignored", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    rsp0_ready = 0; rsp1_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp1_ready = 0;
    chk("cont_grant0_again", {29'd0, rsp1_valid, req1_ready, req0_ready}, 32'd1);
    req0_valid = 0; req1_valid = 0;     // withdraw before being granted
    @(posedge clk); @(negedge clk);
    chk("withdraw_no_accept", {31'd0, busy}, 32'd0);

    // Reset during EXEC drops the operation.
    run_op("pre_rst", 0, 3'b100, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 4'b1001, 0, 4'b1001);
    req1_valid = 1; req1_a = 32'd5; req1_b = 32'd3; req1_ctrl = 3'b101; req1_setflags = 1;
    @(posedge clk); @(negedge clk);
    req1_valid = 0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_flags", {28'd0, flags}, 32'd0);
    chk("mid_rst_result", rsp1_result, 32'd0);
    chk("mid_rst_rflags", {28'd0, rsp0_flags}, 32'd0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_quiet", {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits and the flag vector SHALL be fixed at 4 bits ordered {N,Z,C,V}.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  reset SHALL be asynchronous and active-low.
REQ-004 reqN_valid  in  1  (N=0,1) requester N SHALL use this to present an operation.
REQ-005 reqN_ready  out  1  arbiter SHALL assert this to accept requester N's operation.
REQ-006 reqN_a, reqN_b  in  32  operands; SHALL be sampled only on accept.
REQ-007 reqN_ctrl  in  3  ALU control; SHALL be sampled only on accept.
REQ-008 reqN_setflags  in  1  SHALL request an update of the architectural flag register.
REQ-009 rspN_valid  out  1  SHALL indicate that a result is pending for requester N.
REQ-010 rspN_ready  in  1  requester N SHALL use this to consume the result.
REQ-011 rspN_result  out  32; rspN_flags  out  4; rspN_err  out  1  SHALL carry the result payload.
REQ-012 flags  out  4  SHALL present the architectural NZCV register.
REQ-013 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP, with one transaction outstanding at most.
REQ-015 IDLE: reqN_ready SHALL equal the grant for N (combinational); reqN_ready SHALL be 0 in EXEC and in RESP.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, the grant SHALL go to the requester not granted last; if one is valid, that one SHALL win.
REQ-017 On accept (valid&ready at an edge in IDLE): operands, ctrl, setflags and requester id SHALL be latched, and the state SHALL move to EXEC.
REQ-018 EXEC: the ALU SHALL be driven from the latched registers only; at the end of EXEC, result and flags SHALL be registered, and the state SHALL move to RESP.
REQ-019 Latency: rspN_valid SHALL rise exactly 2 edges after the accept edge.
REQ-020 RESP: rspN_valid SHALL be high for the latched id only, and the payload SHALL be held stable until rspN_ready; the handshake edge SHALL return the state to IDLE.
REQ-021 No bypass: a new accept SHALL NOT occur on the same edge as a response handshake.
REQ-022 Valid ctrl codes SHALL be 000–101; codes 110/111 SHALL give result=0, rspN_flags=0000, rspN_err=1, and the flag register SHALL NOT be updated.
REQ-023 The flag register SHALL load the ALU flags on the EXEC→RESP edge iff setflags=1 and ctrl is valid; otherwise it SHALL hold its value.
REQ-024 rspN_flags SHALL always report this operation's ALU flags (when ctrl is valid), regardless of setflags.
REQ-025 A requester SHALL be able to drop valid before being granted without penalty; once granted, the operation SHALL be committed.
REQ-026 rspN_ready while rspN_valid=0 SHALL be ignored.

Reset
REQ-027 Asserting reset_n=0 SHALL take effect asynchronously: state=IDLE, last-grant=1 (so requester 0 wins first), flags=0000, all rsp*_valid/err=0, result/flag outputs=0, busy=0.
REQ-028 Reset mid-transaction SHALL drop the operation; no response SHALL be produced after release.
REQ-029 Reset release SHALL be treated as synchronous to clk; the first accept SHALL be possible on the first edge after release.

Structure
REQ-030 Package alu_pkg SHALL hold: the state enum {IDLE,EXEC,RESP}, ctrl code constants (AND=000, OR=001, XOR=010, BIC=011, ADD=100, SUB=101), and flag bit indices N=3, Z=2, C=1, V=0.
REQ-031 Exactly one sub-module SHALL be used: the existing alu, instantiated once; no second datapath SHALL be allowed.

Verification
REQ-032 Single op: req0 SUB with a=5, b=3, setflags=1 -> rsp0_valid after 2 edges, result=2, rsp0_flags=0010, flags=0010.
REQ-033 Contention: req0 and req1 both valid from reset -> grant order req0, req1, req0 …; no response SHALL be misrouted.
REQ-034 Flag gating: req1 ADD with a=FFFFFFFF, b=1, setflags=0 -> result=0, rsp1_flags=0110, flags unchanged.
REQ-035 Backpressure: rsp0_ready held low for 5 cycles -> payload stable; req1 ready stays 0 until the handshake, and a grant follows on the next IDLE edge.
REQ-036 Illegal ctrl 111 with setflags=1 -> rsp_err=1, result=0, flags unchanged.
REQ-037 Reset asserted during EXEC -> all outputs at reset values immediately; no rsp_valid after release.
